// File: rtl/cpu_seq_control.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_seq_control: multi-cycle fetch/decode/execute/writeback        |
// | sequencer for a small accumulator CPU.  Rev 1.0                    |
// +--------------------------------------------------------------------+
module cpu_seq_control #(
  parameter int OPW  = 3,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic            is_zero,
  input  logic            mem_ready,
  input  logic            resume,
  output logic            pc_load,
  output logic            pc_en,
  output logic            pc_skip,
  output logic            acc_load,
  output logic            acc_sel,
  output logic            memIns_en,
  output logic            memDa_en,
  output logic            memDa_we,
  output logic            jmp,
  output logic            halted,
  output logic [2:0]      state_o,
  output logic [CNTW-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [OPW-1:0] OP_HLT = OPW'(0);
  localparam logic [OPW-1:0] OP_SKZ = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_AND = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_LDA = OPW'(5);
  localparam logic [OPW-1:0] OP_STO = OPW'(6);
  localparam logic [OPW-1:0] OP_JMP = OPW'(7);

  state_e          state_q, state_d;
  logic [CNTW-1:0] instr_cnt_q, instr_cnt_d;

  logic is_jmp, is_acc_op;

  assign is_jmp    = (opcode == OP_JMP);
  assign is_acc_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_XOR) || (opcode == OP_LDA);

  always_comb begin
    state_d     = state_q;
    instr_cnt_d = instr_cnt_q;
    pc_load     = 1'b0;
    pc_en       = 1'b0;
    pc_skip     = 1'b0;
    acc_load    = 1'b0;
    acc_sel     = 1'b0;
    memIns_en   = 1'b0;
    memDa_en    = 1'b0;
    memDa_we    = 1'b0;
    jmp         = 1'b0;
    halted      = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        memIns_en = 1'b1;
        jmp       = is_jmp;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        memDa_en = 1'b1;
        jmp      = is_jmp;
        if (mem_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        jmp = is_jmp;
        if (is_acc_op) begin
          acc_load = 1'b1;
          acc_sel  = (opcode == OP_LDA);
          state_d  = S_WB;
        end else if (opcode == OP_STO) begin
          // Store strobe is held until memory acknowledges it.
          memDa_we = 1'b1;
          if (mem_ready) state_d = S_WB;
        end else if (opcode == OP_HLT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        jmp = is_jmp;
        if (is_jmp) begin
          pc_load = 1'b1;
        end else begin
          pc_en   = 1'b1;
          pc_skip = (opcode == OP_SKZ) && is_zero;
        end
        instr_cnt_d = instr_cnt_q + CNTW'(1);
        state_d     = S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
        if (resume) state_d = S_WB;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign state_o   = state_q;
  assign instr_cnt = instr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_seq_control.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cpu_seq_control: randomized bench with per-instruction timeline |
// | reference model.  Rev 1.0                                          |
// +--------------------------------------------------------------------+
module tb_cpu_seq_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       is_zero, mem_ready, resume;
  logic       pc_load, pc_en, pc_skip, acc_load, acc_sel;
  logic       memIns_en, memDa_en, memDa_we, jmp, halted;
  logic [2:0] state_o;
  logic [1:0] instr_cnt;
  logic [9:0] obs;

  always #5 clk = ~clk;

  cpu_seq_control #(.OPW(4), .CNTW(2)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .is_zero(is_zero),
    .mem_ready(mem_ready), .resume(resume),
    .pc_load(pc_load), .pc_en(pc_en), .pc_skip(pc_skip),
    .acc_load(acc_load), .acc_sel(acc_sel), .memIns_en(memIns_en),
    .memDa_en(memDa_en), .memDa_we(memDa_we), .jmp(jmp), .halted(halted),
    .state_o(state_o), .instr_cnt(instr_cnt)
  );

  assign obs = {pc_load, pc_en, pc_skip, acc_load, acc_sel,
                memIns_en, memDa_en, memDa_we, jmp, halted};

  localparam logic [9:0] E_PCLD = 10'b10_0000_0000;
  localparam logic [9:0] E_PCEN = 10'b01_0000_0000;
  localparam logic [9:0] E_SKIP = 10'b00_1000_0000;
  localparam logic [9:0] E_ACC  = 10'b00_0100_0000;
  localparam logic [9:0] E_SEL  = 10'b00_0010_0000;
  localparam logic [9:0] E_INS  = 10'b00_0001_0000;
  localparam logic [9:0] E_DA   = 10'b00_0000_1000;
  localparam logic [9:0] E_WE   = 10'b00_0000_0100;
  localparam logic [9:0] E_JMP  = 10'b00_0000_0010;
  localparam logic [9:0] E_HLT  = 10'b00_0000_0001;

  // One entry per clock cycle: what to drive and what must be seen.
  typedef struct packed {
    logic [3:0] op;
    logic [2:0] st;
    logic [9:0] ex;
    logic       mr;
    logic       res;
    logic       iz;
    logic [1:0] cnt;
  } cyc_t;

  cyc_t        plan[$];
  int unsigned m_cnt;
  int          passed = 0;
  int          total  = 0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic [3:0] op, input logic [2:0] st,
                               input logic [9:0] ex, input logic mr,
                               input logic res, input logic iz);
    cyc_t c;
    c.op = op; c.st = st; c.ex = ex; c.mr = mr; c.res = res; c.iz = iz;
    c.cnt = m_cnt[1:0];
    plan.push_back(c);
  endfunction

  // Expands one instruction into its cycle timeline; wf/wd/we are memory
  // wait cycles in fetch, decode and store, hl the halt cycles before resume.
  function automatic void plan_instr(input logic [3:0] op, input int wf,
                                     input int wd, input int we, input int hl,
                                     input logic iz_wb);
    logic [9:0] j;
    j = (op == 4'd7) ? E_JMP : 10'd0;
    push(op, 3'd0, 10'd0, rb(), rb(), rb());
    for (int i = 0; i < wf; i++) push(op, 3'd1, E_INS | j, 1'b0, rb(), rb());
    push(op, 3'd1, E_INS | j, 1'b1, rb(), rb());
    for (int i = 0; i < wd; i++) push(op, 3'd2, E_DA | j, 1'b0, rb(), rb());
    push(op, 3'd2, E_DA | j, 1'b1, rb(), rb());
    if (op >= 4'd2 && op <= 4'd5) begin
      push(op, 3'd3, E_ACC | ((op == 4'd5) ? E_SEL : 10'd0), rb(), rb(), rb());
    end else if (op == 4'd6) begin
      for (int i = 0; i < we; i++) push(op, 3'd3, E_WE, 1'b0, rb(), rb());
      push(op, 3'd3, E_WE, 1'b1, rb(), rb());
    end else begin
      push(op, 3'd3, j, rb(), rb(), rb());
    end
    if (op == 4'd0) begin
      for (int i = 0; i < hl; i++) push(op, 3'd5, E_HLT, rb(), 1'b0, rb());
      push(op, 3'd5, E_HLT, rb(), 1'b1, rb());
    end
    if (op == 4'd7)
      push(op, 3'd4, E_PCLD | E_JMP, rb(), rb(), iz_wb);
    else
      push(op, 3'd4, E_PCEN | ((op == 4'd1 && iz_wb) ? E_SKIP : 10'd0),
           rb(), rb(), iz_wb);
    m_cnt = (m_cnt + 1) % 4;
  endfunction

  task automatic test_reset();
    rst = 1'b1; opcode = 4'($urandom); mem_ready = 1'b1; resume = 1'b1;
    is_zero = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (state_o !== 3'd0) $display("FAIL reset_state: got %0d want 0", state_o);
    else passed++;
    total++;
    if (obs !== 10'd0) $display("FAIL reset_outputs: got %b want 0", obs);
    else passed++;
    total++;
    if (instr_cnt !== 2'd0) $display("FAIL reset_cnt: got %0d want 0", instr_cnt);
    else passed++;
    rst = 1'b0;
    m_cnt = 0;
  endtask

  task automatic test_directed();
    cyc_t c;
    plan_instr(4'd6, 1, 0, 3, 0, 1'b0);  // store with 3 wait cycles
    plan_instr(4'd1, 0, 0, 0, 0, 1'b1);  // skip taken
    plan_instr(4'd1, 0, 0, 0, 0, 1'b0);  // skip not taken
    plan_instr(4'd7, 0, 2, 0, 0, 1'b1);  // jump
    plan_instr(4'd0, 0, 0, 0, 9, 1'b0);  // halt held 10 cycles
    plan_instr(4'd9, 0, 0, 0, 0, 1'b0);  // unmapped opcode
    plan_instr(4'd5, 0, 0, 0, 0, 1'b0);  // load from memory
    while (plan.size() > 0) begin
      c = plan.pop_front();
      opcode = c.op; mem_ready = c.mr; resume = c.res; is_zero = c.iz;
      @(negedge clk);
      total++;
      if (state_o !== c.st)
        $display("FAIL dir_state op=%0d: got %0d want %0d", c.op, state_o, c.st);
      else passed++;
      total++;
      if (obs !== c.ex)
        $display("FAIL dir_outputs op=%0d st=%0d: got %b want %b", c.op, c.st, obs, c.ex);
      else passed++;
      total++;
      if (instr_cnt !== c.cnt)
        $display("FAIL dir_cnt op=%0d: got %0d want %0d", c.op, instr_cnt, c.cnt);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    cyc_t c;
    for (int n = 0; n < 30; n++)
      plan_instr(4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 4), rb());
    while (plan.size() > 0) begin
      c = plan.pop_front();
      opcode = c.op; mem_ready = c.mr; resume = c.res; is_zero = c.iz;
      @(negedge clk);
      total++;
      if (state_o !== c.st)
        $display("FAIL rnd_state op=%0d: got %0d want %0d", c.op, state_o, c.st);
      else passed++;
      total++;
      if (obs !== c.ex)
        $display("FAIL rnd_outputs op=%0d st=%0d: got %b want %b", c.op, c.st, obs, c.ex);
      else passed++;
      total++;
      if (instr_cnt !== c.cnt)
        $display("FAIL rnd_cnt op=%0d: got %0d want %0d", c.op, instr_cnt, c.cnt);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    cyc_t c;
    int   n;
    int   pulses;
    n = ((m_cnt + 5) % 4 != 0) ? 5 : 6;
    pulses = 0;
    for (int i = 0; i < n; i++) plan_instr(4'd2, 0, 0, 0, 0, 1'b0);
    while (plan.size() > 0) begin
      c = plan.pop_front();
      opcode = c.op; mem_ready = 1'b1; resume = c.res; is_zero = c.iz;
      @(negedge clk);
      if (acc_load === 1'b1) pulses++;
      total++;
      if (state_o !== c.st)
        $display("FAIL b2b_state: got %0d want %0d", state_o, c.st);
      else passed++;
      total++;
      if (obs !== c.ex)
        $display("FAIL b2b_outputs st=%0d: got %b want %b", c.st, obs, c.ex);
      else passed++;
      total++;
      if (instr_cnt !== c.cnt)
        $display("FAIL b2b_cnt: got %0d want %0d", instr_cnt, c.cnt);
      else passed++;
      @(posedge clk); #1;
    end
    total++;
    if (pulses !== n) $display("FAIL b2b_acc_pulses: got %0d want %0d", pulses, n);
    else passed++;
  endtask

  task automatic test_reset_midwait();
    // Reset during a decode wait, with mem_ready high on the same edge.
    opcode = 4'd7; mem_ready = 1'b1; resume = 1'b0;
    @(posedge clk); #1;              // now FETCH
    @(posedge clk); #1;              // now DECODE
    mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (state_o !== 3'd2) $display("FAIL mid_pre_state: got %0d want 2", state_o);
    else passed++;
    total++;
    if (instr_cnt !== m_cnt[1:0])
      $display("FAIL mid_pre_cnt: got %0d want %0d", instr_cnt, m_cnt[1:0]);
    else passed++;
    @(posedge clk); #1;
    mem_ready = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (state_o !== 3'd0) $display("FAIL mid_rst_state: got %0d want 0", state_o);
    else passed++;
    total++;
    if (obs !== 10'd0) $display("FAIL mid_rst_outputs: got %b want 0", obs);
    else passed++;
    total++;
    if (instr_cnt !== 2'd0) $display("FAIL mid_rst_cnt: got %0d want 0", instr_cnt);
    else passed++;
    m_cnt = 0;
    // Reset in HALT beats a simultaneous resume.
    opcode = 4'd0; mem_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    total++;
    if (halted !== 1'b1 || state_o !== 3'd5)
      $display("FAIL halt_pre: got halted=%b state=%0d want 1/5", halted, state_o);
    else passed++;
    @(posedge clk); #1;
    resume = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; resume = 1'b0;
    total++;
    if (state_o !== 3'd0) $display("FAIL halt_rst_state: got %0d want 0", state_o);
    else passed++;
    total++;
    if (obs !== 10'd0) $display("FAIL halt_rst_outputs: got %b want 0", obs);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midwait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
